xor_scrambler: RTL and testbench
================================

// Module: xor_scrambler
//
// PURPOSE
//   Parametrised streaming additive scrambler built on XOR primitives.
//   XORs each WIDTH-bit input beat with a keystream from a Fibonacci LFSR.
//   The transform is self-inverse: the same block with the same seed descrambles.
//   Sits between a valid/ready source and sink. Latency is 1 cycle; full rate is one beat/cycle.
//
// PARAMETERS
//   WIDTH     8      data bits per beat (>=1)
//   LFSR_LEN  7      LFSR state length in bits (2..32)
//   TAPS      7'h60  feedback tap mask; bit k set => state[k] in feedback (x^7+x^6+1)
//   SEED      7'h7F  reset/reload state; must be nonzero (elaboration $error if 0)
//
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   init       in   1      synchronous reload of LFSR to SEED
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block can accept input beat
//   in_data    in   WIDTH  input beat
//   out_valid  out  1      output beat valid
//   out_ready  in   1      sink accepts output beat
//   out_data   out  WIDTH  scrambled beat
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=SEED, out_valid=0, out_data=0. in_ready is 0 during reset.
//   - LFSR step: ks_bit=state[LFSR_LEN-1]; fb=^(state & TAPS); state<={state[LFSR_LEN-2:0],fb}.
//   - Per accepted beat (in_valid & in_ready), the LFSR advances exactly WIDTH steps.
//     The keystream word bit i is the ks_bit of step i (bit 0 first).
//   - out_data <= in_data ^ keystream, registered. Latency is exactly 1 clk.
//   - in_ready = !out_valid | out_ready. Back-to-back beats with no bubbles are allowed.
//   - out_valid: set on accept; cleared on (out_valid & out_ready & no new accept).
//   - out_data and out_valid hold stable while out_valid & !out_ready.
//   - LFSR does not advance on idle cycles or when stalled.
//   - init: the state is treated as SEED for this cycle's beat.
//     - A beat accepted in the same cycle is scrambled from SEED.
//     - Next state = SEED advanced WIDTH steps if a beat is accepted, else SEED.
//     - init does not affect out_valid or out_data (an in-flight beat still completes).
//   - Reset mid-stream drops any pending output beat (out_valid->0 immediately).
//   - All-zero state is unreachable given a nonzero SEED. No lock-up recovery is needed.
//
// CONFIGURATION
//   `XOR_SCRAMBLER_BYPASS_EN defined:
//     - Adds input port bypass (1 bit).
//     - A beat accepted with bypass=1: out_data=in_data unmodified, and the LFSR does not advance.
//     - init is still honoured.
//   Undefined: port absent; every beat is scrambled.
//
// STRUCTURE
//   Package xor_pkg holds:
//     - default constants XOR_DEF_TAPS=7'h60 and XOR_DEF_SEED=7'h7F
//     - the function lfsr_step1 (single-step next state)
//   Sub-module xor_lfsr_step:
//     - combinational WIDTH-step unroll: state_in -> {keystream[WIDTH-1:0], state_out}
//     - parametrised by WIDTH, LFSR_LEN and TAPS
//   Top level holds:
//     - the state register and output register
//     - the handshake logic
//
// TESTING (defaults: WIDTH=8, LFSR_LEN=7, TAPS=7'h60, SEED=7'h7F)
//   1. Reset, then beat 8'h00 -> out_data=8'h7F one clk later; internal state=7'h02.
//   2. Beats 8'h00, 8'h00 back-to-back -> out_data 8'h7F then 8'h20, no bubble.
//      Final state=7'h0C.
//   3. Stall: out_ready=0 for 3 clks after beat 1 -> in_ready=0, out_data holds 8'h7F.
//      Second beat yields 8'h20 once released.
//   4. Round-trip: scramble 8'hA5 (gives 8'hDA), then pulse init and feed 8'hDA.
//      Expect out_data=8'hA5.
//   5. init coincident with a beat mid-stream -> that beat out = in_data^8'h7F.
//      rst_n low while out_valid=1 -> out_valid=0 asynchronously.
//   6. With `XOR_SCRAMBLER_BYPASS_EN: bypass beat 8'h3C -> 8'h3C.
//      The following normal beat 8'h00 -> 8'h7F (LFSR unadvanced).

Source files
------------

// File: rtl/xor_pkg.sv
// rtl/xor_pkg.sv - shared constants and single-step LFSR helper for the XOR scrambler
package xor_pkg;

    localparam logic [6:0] XOR_DEF_TAPS = 7'h60;
    localparam logic [6:0] XOR_DEF_SEED = 7'h7F;

    // Fibonacci step on a zero-extended state; bits above len are masked off
    function automatic logic [31:0] lfsr_step1(input logic [31:0] state,
                                               input logic [31:0] taps,
                                               input int          len);
        logic [31:0] mask;
        logic        fb;
        mask = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
        fb   = ^(state & taps & mask);
        return ((state << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/xor_scrambler_if.sv
// rtl/xor_scrambler_if.sv - valid/ready input and output streams of the scrambler
interface xor_scrambler_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/xor_lfsr_step.sv
// rtl/xor_lfsr_step.sv - combinational WIDTH-step LFSR unroll producing one keystream word
module xor_lfsr_step
    import xor_pkg::*;
#(
    parameter int                  WIDTH    = 8,
    parameter int                  LFSR_LEN = 7,
    parameter logic [LFSR_LEN-1:0] TAPS     = LFSR_LEN'(XOR_DEF_TAPS)
) (
    input  logic [LFSR_LEN-1:0] state_in,
    output logic [WIDTH-1:0]    keystream,
    output logic [LFSR_LEN-1:0] state_out
);

    logic [31:0] s;

    always_comb begin
        keystream = '0;
        s         = 32'(state_in);
        for (int i = 0; i < WIDTH; i++) begin
            keystream[i] = s[LFSR_LEN-1];
            s            = lfsr_step1(s, 32'(TAPS), LFSR_LEN);
        end
        state_out = s[LFSR_LEN-1:0];
    end

endmodule

// File: rtl/xor_scrambler.sv
// rtl/xor_scrambler.sv - streaming additive LFSR scrambler, optional XOR_SCRAMBLER_BYPASS_EN
module xor_scrambler
    import xor_pkg::*;
#(
    parameter int                  WIDTH    = 8,
    parameter int                  LFSR_LEN = 7,
    parameter logic [LFSR_LEN-1:0] TAPS     = LFSR_LEN'(XOR_DEF_TAPS),
    parameter logic [LFSR_LEN-1:0] SEED     = LFSR_LEN'(XOR_DEF_SEED)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic init,
`ifdef XOR_SCRAMBLER_BYPASS_EN
    input  logic bypass,
`endif
    xor_scrambler_if.slave bus
);

    if (SEED == '0) begin : g_seed_chk
        $error("xor_scrambler: SEED must be nonzero");
    end
    if (LFSR_LEN < 2 || LFSR_LEN > 32) begin : g_len_chk
        $error("xor_scrambler: LFSR_LEN must be in 2..32");
    end

    logic [LFSR_LEN-1:0] state_q;
    logic [LFSR_LEN-1:0] state_eff;
    logic [LFSR_LEN-1:0] state_adv;
    logic [WIDTH-1:0]    ks;
    logic [WIDTH-1:0]    out_data_q;
    logic                out_valid_q;
    logic                accept;
    logic                scramble;

    // init reloads combinationally so a beat in the same cycle already sees SEED
    assign state_eff = init ? SEED : state_q;

    xor_lfsr_step #(
        .WIDTH    (WIDTH),
        .LFSR_LEN (LFSR_LEN),
        .TAPS     (TAPS)
    ) u_step (
        .state_in  (state_eff),
        .keystream (ks),
        .state_out (state_adv)
    );

    assign bus.in_ready  = rst_n & (!out_valid_q | bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign accept        = bus.in_valid & bus.in_ready;

`ifdef XOR_SCRAMBLER_BYPASS_EN
    assign scramble = accept & !bypass;
`else
    assign scramble = accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q <= scramble ? state_adv : state_eff;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data ^ (scramble ? ks : '0);
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xor_scrambler.sv
// tb/tb_xor_scrambler.sv - directed table-driven bench for xor_scrambler (default parameters)
module tb_xor_scrambler;

    logic clk;
    logic rst_n;
    logic init;
`ifdef XOR_SCRAMBLER_BYPASS_EN
    logic bypass;
`endif

    xor_scrambler_if #(.WIDTH(8)) bus ();

    xor_scrambler dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .init   (init),
`ifdef XOR_SCRAMBLER_BYPASS_EN
        .bypass (bypass),
`endif
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       init;
        logic [7:0] din;
        logic [7:0] dout;
        logic [6:0] st;
    } vec_t;

    vec_t vecs[7];

    task automatic do_reset();
        rst_n         = 1'b0;
        init          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
`ifdef XOR_SCRAMBLER_BYPASS_EN
        bypass        = 1'b0;
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // back-to-back stream: {init, in_data, expected out_data, expected state after}
        vecs[0] = '{1'b0, 8'h00, 8'h7F, 7'h02};
        vecs[1] = '{1'b0, 8'h00, 8'h20, 7'h0C};
        vecs[2] = '{1'b1, 8'hA5, 8'hDA, 7'h02};
        vecs[3] = '{1'b0, 8'hFF, 8'hDF, 7'h0C};
        vecs[4] = '{1'b1, 8'hDA, 8'hA5, 7'h02};
        vecs[5] = '{1'b1, 8'h00, 8'h7F, 7'h02};
        vecs[6] = '{1'b0, 8'h0F, 8'h2F, 7'h0C};

        rst_n         = 1'b0;
        init          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;
`ifdef XOR_SCRAMBLER_BYPASS_EN
        bypass        = 1'b0;
`endif
        #12;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'h00);
        check("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;

        // table: continuous stream, one beat per clock, sink always ready
        for (int i = 0; i < 7; i++) begin
            init         = vecs[i].init;
            bus.in_valid = 1'b1;
            bus.in_data  = vecs[i].din;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_out_data", i), 32'(bus.out_data), 32'(vecs[i].dout));
            check($sformatf("vec%0d_state", i), 32'(dut.state_q), 32'(vecs[i].st));
        end
        bus.in_valid = 1'b0;
        init         = 1'b0;
        @(posedge clk);
        #1;
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_state_hold", 32'(dut.state_q), 32'h0C);

        // stall: sink blocks for 3 clocks after the first beat
        do_reset();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        @(posedge clk);
        #1;
        check("stall_first_out", 32'(bus.out_data), 32'h7F);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("stall%0d_out_data", c), 32'(bus.out_data), 32'h7F);
            check($sformatf("stall%0d_state", c), 32'(dut.state_q), 32'h02);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_data", 32'(bus.out_data), 32'h20);
        check("release_state", 32'(dut.state_q), 32'h0C);
        bus.in_valid = 1'b0;

        // init on an idle cycle reloads SEED but leaves the held output alone
        bus.out_ready = 1'b0;
        init          = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        check("init_idle_state", 32'(dut.state_q), 32'h7F);
        check("init_idle_out_valid", 32'(bus.out_valid), 32'd1);
        check("init_idle_out_data", 32'(bus.out_data), 32'h20);

        // asynchronous reset drops the pending beat without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_state", 32'(dut.state_q), 32'h7F);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;

`ifdef XOR_SCRAMBLER_BYPASS_EN
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        bypass       = 1'b1;
        @(posedge clk);
        #1;
        check("bypass_out_data", 32'(bus.out_data), 32'h3C);
        check("bypass_state", 32'(dut.state_q), 32'h7F);
        bypass      = 1'b0;
        bus.in_data = 8'h00;
        @(posedge clk);
        #1;
        check("post_bypass_out_data", 32'(bus.out_data), 32'h7F);
        bus.in_valid = 1'b0;
`endif

        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
